// File: rtl/cpu_consts_pkg.sv
// Shared enums for the pattern history table: index hash selection and table FSM states.
package cpu_consts;
  typedef enum logic {PHT_HASH_CONCAT, PHT_HASH_GSHARE} pht_hash_e;
  typedef enum logic {PHT_INIT, PHT_RUN} pht_state_e;
endpackage

// File: rtl/bp_sat_cnt.sv
// Combinational CNT_W-bit saturating counter step: taken increments, not-taken decrements, no wrap.
module bp_sat_cnt #(
  parameter int CNT_W = 2
) (
  input  logic [CNT_W-1:0] old_cnt,
  input  logic             taken,
  output logic [CNT_W-1:0] new_cnt
);
  always_comb begin
    new_cnt = old_cnt;
    if (taken) begin
      if (old_cnt != '1) new_cnt = old_cnt + 1'b1;
    end else begin
      if (old_cnt != '0) new_cnt = old_cnt - 1'b1;
    end
  end
endmodule

// File: rtl/bp_pht_param.sv
// Parametrised PHT: registered lookup, two-stage read-modify-write training, reset-time init sweep.
module bp_pht_param
  import cpu_consts::*;
#(
  parameter int               PC_W      = 8,
  parameter int               HIST_W    = 10,
  parameter int               CNT_W     = 2,
  parameter pht_hash_e        HASH_MODE = PHT_HASH_CONCAT,
  parameter logic [CNT_W-1:0] INIT_VAL  = CNT_W'((1 << (CNT_W-1)) - 1)
) (
  input  logic              clk,
  input  logic              reset,
  output logic              ready_o,
  input  logic              rd_valid_i,
  input  logic [PC_W-1:0]   pc_slice_i,
  input  logic [HIST_W-1:0] bhr_i,
  output logic              rd_valid_o,
  output logic [CNT_W-1:0]  cnt_o,
  output logic              taken_o,
  input  logic              update_en_i,
  input  logic [PC_W-1:0]   pc_slice_u_i,
  input  logic [HIST_W-1:0] bhr_u_i,
  input  logic              taken_u_i
);
  localparam int IDX_W = (HASH_MODE == PHT_HASH_GSHARE) ? ((PC_W > HIST_W) ? PC_W : HIST_W)
                                                         : (PC_W + HIST_W);
  localparam int DEPTH = 1 << IDX_W;

  function automatic logic [IDX_W-1:0] pht_hash(input logic [PC_W-1:0] pc,
                                                input logic [HIST_W-1:0] bhr);
    if (HASH_MODE == PHT_HASH_GSHARE) return IDX_W'(pc) ^ IDX_W'(bhr);
    return IDX_W'({bhr, pc});
  endfunction

  logic [CNT_W-1:0] mem [DEPTH];

  pht_state_e       state_q, state_d;
  logic [IDX_W-1:0] sweep_idx_q, sweep_idx_d;
  logic             run;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= PHT_INIT;
      sweep_idx_q <= '0;
    end else begin
      state_q     <= state_d;
      sweep_idx_q <= sweep_idx_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    sweep_idx_d = sweep_idx_q;
    if (state_q == PHT_INIT) begin
      sweep_idx_d = sweep_idx_q + 1'b1;
      if (sweep_idx_q == '1) state_d = PHT_RUN;
    end
  end

  assign run     = (state_q == PHT_RUN);
  assign ready_o = run;

  logic [IDX_W-1:0] rd_idx, up_idx;
  assign rd_idx = pht_hash(pc_slice_i, bhr_i);
  assign up_idx = pht_hash(pc_slice_u_i, bhr_u_i);

  // U2 stage registers; old value is captured at the U1 edge, bypassing the write landing on that same edge.
  logic             u_vld_q, u_taken_q;
  logic [IDX_W-1:0] u_idx_q;
  logic [CNT_W-1:0] u_old_q, u_new;

  always_ff @(posedge clk) begin
    if (!reset) u_vld_q <= 1'b0;
    else        u_vld_q <= run & update_en_i;
  end

  always_ff @(posedge clk) begin
    u_idx_q   <= up_idx;
    u_taken_q <= taken_u_i;
    u_old_q   <= (u_vld_q && u_idx_q == up_idx) ? u_new : mem[up_idx];
  end

  bp_sat_cnt #(.CNT_W(CNT_W)) u_sat (
    .old_cnt (u_old_q),
    .taken   (u_taken_q),
    .new_cnt (u_new)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_valid_o <= 1'b0;
      cnt_o      <= INIT_VAL;
    end else begin
      rd_valid_o <= run & rd_valid_i;
      if (run && rd_valid_i)
        cnt_o <= (u_vld_q && u_idx_q == rd_idx) ? u_new : mem[rd_idx];
    end
  end

  assign taken_o = cnt_o[CNT_W-1];

  // Single write port: sweep owns it during INIT, U2 during RUN.
  logic             we;
  logic [IDX_W-1:0] waddr;
  logic [CNT_W-1:0] wdata;

  always_comb begin
    we    = 1'b0;
    waddr = sweep_idx_q;
    wdata = INIT_VAL;
    if (!run) begin
      we = 1'b1;
    end else if (u_vld_q) begin
      we    = 1'b1;
      waddr = u_idx_q;
      wdata = u_new;
    end
  end

  always_ff @(posedge clk) begin
    if (reset && we) mem[waddr] <= wdata;
  end
endmodule

// File: tb/tb_bp_pht_param.sv
// Bench for bp_pht_param: three configurations share one stimulus stream and are checked against an array model.
module tb_bp_pht_param;
  import cpu_consts::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rd_valid_i = 1'b0, update_en_i = 1'b0, taken_u_i = 1'b0;
  logic [3:0] pc_slice_i = '0, bhr_i = '0, pc_slice_u_i = '0, bhr_u_i = '0;

  logic       ready0, ready1, ready2, rv0, rv1, rv2, tk0, tk1, tk2;
  logic [1:0] cnt0, cnt1;
  logic [2:0] cnt2;

  always #5 clk = ~clk;

  bp_pht_param #(.PC_W(4), .HIST_W(4), .CNT_W(2), .HASH_MODE(PHT_HASH_CONCAT)) dut0 (
    .clk(clk), .reset(reset), .ready_o(ready0), .rd_valid_i(rd_valid_i), .pc_slice_i(pc_slice_i),
    .bhr_i(bhr_i), .rd_valid_o(rv0), .cnt_o(cnt0), .taken_o(tk0), .update_en_i(update_en_i),
    .pc_slice_u_i(pc_slice_u_i), .bhr_u_i(bhr_u_i), .taken_u_i(taken_u_i));

  bp_pht_param #(.PC_W(4), .HIST_W(4), .CNT_W(2), .HASH_MODE(PHT_HASH_GSHARE)) dut1 (
    .clk(clk), .reset(reset), .ready_o(ready1), .rd_valid_i(rd_valid_i), .pc_slice_i(pc_slice_i),
    .bhr_i(bhr_i), .rd_valid_o(rv1), .cnt_o(cnt1), .taken_o(tk1), .update_en_i(update_en_i),
    .pc_slice_u_i(pc_slice_u_i), .bhr_u_i(bhr_u_i), .taken_u_i(taken_u_i));

  bp_pht_param #(.PC_W(4), .HIST_W(4), .CNT_W(3), .HASH_MODE(PHT_HASH_CONCAT)) dut2 (
    .clk(clk), .reset(reset), .ready_o(ready2), .rd_valid_i(rd_valid_i), .pc_slice_i(pc_slice_i),
    .bhr_i(bhr_i), .rd_valid_o(rv2), .cnt_o(cnt2), .taken_o(tk2), .update_en_i(update_en_i),
    .pc_slice_u_i(pc_slice_u_i), .bhr_u_i(bhr_u_i), .taken_u_i(taken_u_i));

  int n_tests = 0, n_fail = 0;

  // Reference model: one array per configuration, updated instantly; lookups see state before this cycle's update.
  int m0[256], m1[16], m2[256];
  int e0, e1, e2, ev;

  typedef struct {
    bit u; int pu; int bu; bit tu;
    bit r; int pr; int br;
    int ev; int ec;
  } vec_t;
  vec_t tbl[14];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int sat(input int v, input bit t, input int mx);
    if (t) return (v < mx) ? v + 1 : mx;
    return (v > 0) ? v - 1 : 0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_init();
    for (int i = 0; i < 256; i++) begin m0[i] = 1; m2[i] = 3; end
    for (int i = 0; i < 16; i++) m1[i] = 1;
    e0 = 1; e1 = 1; e2 = 3; ev = 0;
  endtask

  task automatic cyc(input bit u, input int pu, input int bu, input bit tu,
                     input bit r, input int pr, input int br);
    update_en_i = u; pc_slice_u_i = 4'(pu); bhr_u_i = 4'(bu); taken_u_i = tu;
    rd_valid_i = r;  pc_slice_i = 4'(pr);   bhr_i = 4'(br);
    ev = r;
    if (r) begin
      e0 = m0[br*16 + pr];
      e1 = m1[pr ^ br];
      e2 = m2[br*16 + pr];
    end
    if (u) begin
      m0[bu*16 + pu] = sat(m0[bu*16 + pu], tu, 3);
      m1[pu ^ bu]    = sat(m1[pu ^ bu], tu, 3);
      m2[bu*16 + pu] = sat(m2[bu*16 + pu], tu, 7);
    end
    step();
    update_en_i = 1'b0;
    rd_valid_i  = 1'b0;
  endtask

  task automatic check_all(input string name);
    check({name, "_vld0"}, int'(rv0), ev);
    check({name, "_cnt0"}, int'(cnt0), e0);
    check({name, "_tk0"}, int'(tk0), e0 / 2);
    check({name, "_vld1"}, int'(rv1), ev);
    check({name, "_cnt1"}, int'(cnt1), e1);
    check({name, "_tk1"}, int'(tk1), e1 / 2);
    check({name, "_vld2"}, int'(rv2), ev);
    check({name, "_cnt2"}, int'(cnt2), e2);
    check({name, "_tk2"}, int'(tk2), e2 / 4);
  endtask

  // Counts post-release cycles until each instance reports ready; optionally pokes requests that must be dropped.
  task automatic sweep(input bit poke, input int exp0);
    int c0, c1, c2;
    bit early;
    c0 = -1; c1 = -1; c2 = -1; early = 0;
    if (poke) begin
      update_en_i = 1'b1; pc_slice_u_i = 4'd5; bhr_u_i = 4'd3; taken_u_i = 1'b1;
      rd_valid_i  = 1'b1; pc_slice_i   = 4'd5; bhr_i   = 4'd3;
    end
    for (int i = 1; i <= 400; i++) begin
      step();
      if (ready1 && c1 < 0) begin c1 = i; update_en_i = 1'b0; rd_valid_i = 1'b0; end
      if (ready0 && c0 < 0) c0 = i;
      if (ready2 && c2 < 0) c2 = i;
      if ((rv0 && i <= 256) || (rv2 && i <= 256) || (rv1 && i <= 16)) early = 1;
      if (c0 > 0 && c1 > 0 && c2 > 0) break;
    end
    check("sweep_len0", c0, exp0);
    check("sweep_len1", c1, 16);
    check("sweep_len2", c2, exp0);
    check("init_drop", int'(early), 0);
  endtask

  initial begin
    model_init();
    // Reset state
    step(); step(); step();
    check("rst_ready", int'(ready0 | ready1 | ready2), 0);
    check("rst_vld", int'(rv0 | rv1 | rv2), 0);
    check("rst_cnt0", int'(cnt0), 1);
    check("rst_cnt1", int'(cnt1), 1);
    check("rst_cnt2", int'(cnt2), 3);
    reset = 1'b1;
    sweep(1'b1, 256);

    // Every entry reads back the init value
    for (int i = 0; i < 256; i++) begin
      cyc(0, 0, 0, 0, 1, i % 16, i / 16);
      check_all("init_rd");
      check("init_cnt0", int'(cnt0), 1);
    end
    cyc(0, 0, 0, 0, 0, 0, 0);
    check_all("hold");

    // gshare aliasing: pc=A,bhr=5 and pc=F,bhr=0 share index F
    cyc(1, 10, 5, 0, 0, 0, 0);
    check_all("t5_upd");
    cyc(0, 0, 0, 0, 1, 15, 0);
    check_all("t5_fwd");
    check("t5_alias_fwd", int'(cnt1), 0);
    cyc(0, 0, 0, 0, 1, 15, 0);
    check("t5_alias_arr", int'(cnt1), 0);

    // 3-bit counter saturates at 0 without wrapping, then steps back up
    for (int k = 0; k <= 11; k++) begin
      cyc(k <= 10, 9, 9, k == 10, 1, 9, 9);
      check_all("t6");
      check($sformatf("t6_sat_%0d", k), int'(cnt2), (k <= 3) ? 3 - k : (k == 11 ? 1 : 0));
    end

    // Directed hazard vectors for the 2-bit concat table
    tbl[0]  = '{1, 5, 3, 1, 1, 5, 3, 1, 1};
    tbl[1]  = '{1, 5, 3, 1, 1, 5, 3, 1, 2};
    tbl[2]  = '{1, 5, 3, 1, 1, 5, 3, 1, 3};
    tbl[3]  = '{1, 5, 3, 1, 1, 5, 3, 1, 3};
    tbl[4]  = '{0, 0, 0, 0, 1, 5, 3, 1, 3};
    tbl[5]  = '{1, 2, 7, 1, 1, 2, 7, 1, 1};
    tbl[6]  = '{0, 0, 0, 0, 1, 2, 7, 1, 2};
    tbl[7]  = '{0, 0, 0, 0, 0, 0, 0, 0, 2};
    tbl[8]  = '{0, 0, 0, 0, 1, 2, 7, 1, 2};
    tbl[9]  = '{1, 1, 1, 0, 1, 2, 1, 1, 1};
    tbl[10] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
    tbl[11] = '{1, 1, 1, 0, 1, 1, 1, 1, 0};
    tbl[12] = '{1, 1, 1, 1, 1, 1, 1, 1, 0};
    tbl[13] = '{0, 0, 0, 0, 1, 1, 1, 1, 1};
    for (int v = 0; v < 14; v++) begin
      cyc(tbl[v].u, tbl[v].pu, tbl[v].bu, tbl[v].tu, tbl[v].r, tbl[v].pr, tbl[v].br);
      check($sformatf("vec%0d_vld", v), int'(rv0), tbl[v].ev);
      check($sformatf("vec%0d_cnt", v), int'(cnt0), tbl[v].ec);
      check_all($sformatf("vec%0d", v));
    end

    // Random traffic on a small index neighbourhood to stress the hazard paths
    for (int n = 0; n < 400; n++) begin
      cyc($urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1),
          $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 3));
      check_all("rand");
    end

    // Reset in the middle of a sweep restarts it and discards training
    reset = 1'b0;
    step();
    reset = 1'b1;
    for (int i = 0; i < 100; i++) step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    model_init();
    check("t4_ready_low", int'(ready0), 0);
    sweep(1'b0, 256);
    cyc(0, 0, 0, 0, 1, 5, 3);
    check_all("t4_rd");
    check("t4_lost", int'(cnt0), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
